// File: rtl/fifo_pkg.sv
// Shared defaults and the status bundle for the programmable-threshold synchronous FIFO.
package fifo_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 4;

    typedef struct packed {
        logic wfull;
        logic walmost_full;
        logic rempty;
        logic ralmost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DSIZE storage: one synchronous write port and one registered read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             re,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    logic [DSIZE-1:0] mem [2**ASIZE];

    // The storage array needs no reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with wrap-bit pointers, programmable almost-full/empty levels,
// flush, and sticky overflow/underflow flags.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int DSIZE    = DSIZE_DEF,
    parameter int ASIZE    = ASIZE_DEF,
    parameter int AF_LEVEL = (2**ASIZE) - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             flush,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rinc,
    input  logic             err_clr,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             walmost_full,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   wcount,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = 2**ASIZE;

    if (AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH) begin : g_bad_levels
        $error("sync_fifo_prog: AF_LEVEL must be <= DEPTH and AE_LEVEL < DEPTH");
    end

    localparam logic [ASIZE:0] AF_CNT = AF_LEVEL[ASIZE:0];
    localparam logic [ASIZE:0] AE_CNT = AE_LEVEL[ASIZE:0];

    logic [ASIZE:0] wptr;
    logic [ASIZE:0] rptr;
    logic           ovf_q;
    logic           udf_q;
    logic           wr_ok;
    logic           rd_ok;
    fifo_status_t   status;

    assign wcount = wptr - rptr;

    always_comb begin
        status               = '0;
        status.rempty        = (wptr == rptr);
        status.wfull         = (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]) &&
                               (wptr[ASIZE] != rptr[ASIZE]);
        status.walmost_full  = (wcount >= AF_CNT);
        status.ralmost_empty = (wcount <= AE_CNT);
        status.overflow      = ovf_q;
        status.underflow     = udf_q;
    end

    // A write into a full FIFO is legal when a read frees the slot in the same edge.
    assign wr_ok = !wrst && !flush && winc && (!status.wfull || rinc);
    assign rd_ok = !wrst && !flush && rinc && !status.rempty;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wptr  <= '0;
            rptr  <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok)
                wptr <= wptr + 1'b1;
            if (rd_ok)
                rptr <= rptr + 1'b1;
            // Clear first so a coinciding error event wins.
            if (err_clr) begin
                ovf_q <= 1'b0;
                udf_q <= 1'b0;
            end
            if (winc && status.wfull && !rinc)
                ovf_q <= 1'b1;
            if (rinc && status.rempty)
                udf_q <= 1'b1;
        end
    end

    fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk   (wclk),
        .rst   (wrst),
        .we    (wr_ok),
        .waddr (wptr[ASIZE-1:0]),
        .wdata (wdata),
        .re    (rd_ok),
        .raddr (rptr[ASIZE-1:0]),
        .rdata (rdata)
    );

    assign wfull         = status.wfull;
    assign walmost_full  = status.walmost_full;
    assign rempty        = status.rempty;
    assign ralmost_empty = status.ralmost_empty;
    assign overflow      = status.overflow;
    assign underflow     = status.underflow;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_sync_fifo_prog;

    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int DEPTH = 16;
    localparam int AFL   = 14;
    localparam int AEL   = 2;

    logic             wclk = 1'b0;
    logic             wrst, flush, winc, rinc, err_clr;
    logic [DSIZE-1:0] wdata;
    logic [DSIZE-1:0] rdata;
    logic             wfull, walmost_full, rempty, ralmost_empty;
    logic [ASIZE:0]   wcount;
    logic             overflow, underflow;

    always #5 wclk = ~wclk;

    sync_fifo_prog #(
        .DSIZE    (DSIZE),
        .ASIZE    (ASIZE),
        .AF_LEVEL (AFL),
        .AE_LEVEL (AEL)
    ) dut (
        .wclk          (wclk),
        .wrst          (wrst),
        .flush         (flush),
        .winc          (winc),
        .wdata         (wdata),
        .rinc          (rinc),
        .err_clr       (err_clr),
        .rdata         (rdata),
        .wfull         (wfull),
        .walmost_full  (walmost_full),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .wcount        (wcount),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: contents as a queue, plus read register and sticky flags.
    logic [DSIZE-1:0] q[$];
    logic [DSIZE-1:0] m_rd  = '0;
    logic             m_ovf = 1'b0;
    logic             m_udf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        chk("rdata",         32'(rdata),         32'(m_rd));
        chk("wcount",        32'(wcount),        32'(sz));
        chk("wfull",         32'(wfull),         32'(sz == DEPTH));
        chk("walmost_full",  32'(walmost_full),  32'(sz >= AFL));
        chk("rempty",        32'(rempty),        32'(sz == 0));
        chk("ralmost_empty", 32'(ralmost_empty), 32'(sz <= AEL));
        chk("overflow",      32'(overflow),      32'(m_ovf));
        chk("underflow",     32'(underflow),     32'(m_udf));
    endtask

    task automatic step(input logic r, input logic f, input logic w, input logic rd,
                        input logic ec, input logic [DSIZE-1:0] d);
        bit full, empty;
        wrst = r; flush = f; winc = w; rinc = rd; err_clr = ec; wdata = d;
        @(posedge wclk);
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        if (r) begin
            q.delete();
            m_rd  = '0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (f) begin
            q.delete();
        end else begin
            if (rd && !empty)
                m_rd = q.pop_front();
            if (w && (!full || rd))
                q.push_back(d);
            if (ec) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            if (w && full && !rd)
                m_ovf = 1'b1;
            if (rd && empty)
                m_udf = 1'b1;
        end
        @(negedge wclk);
        check_all();
    endtask

    initial begin
        wrst = 1'b1; flush = 1'b0; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0; wdata = '0;

        // Reset for two cycles.
        step(1, 0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);
        chk("rst_rempty",   32'(rempty),   32'd1);
        chk("rst_wcount",   32'(wcount),   32'd0);
        chk("rst_rdata",    32'(rdata),    32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Fill with 0x00..0x0F, overflow on the 17th, drain in order.
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 0, 0, 8'(i));
            if (i == 12) chk("af_before_14", 32'(walmost_full), 32'd0);
            if (i == 13) chk("af_at_14",     32'(walmost_full), 32'd1);
            if (i == 14) chk("full_at_15",   32'(wfull),        32'd0);
        end
        chk("full_at_16", 32'(wfull), 32'd1);
        step(0, 0, 1, 0, 0, 8'hEE);
        chk("ovf_17th", 32'(overflow), 32'd1);
        chk("cnt_17th", 32'(wcount),   32'd16);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 1, 0, 8'h00);
            chk("drain_order", 32'(rdata), 32'(i));
        end
        step(0, 0, 0, 0, 1, 8'h00);

        // Full FIFO with simultaneous read/write across pointer wrap.
        for (int i = 0; i < 16; i++)
            step(0, 0, 1, 0, 0, 8'(8'h20 + i));
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 1, 0, 8'hA5);
            chk("wrap_order", 32'(rdata), (i < 16) ? 32'(8'h20 + i) : 32'hA5);
        end
        chk("wrap_no_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++)
            step(0, 0, 0, 1, 0, 8'h00);

        // Empty FIFO: underflow, then write+read accepts the write only.
        step(0, 0, 0, 1, 0, 8'h00);
        chk("udf_set", 32'(underflow), 32'd1);
        step(0, 0, 1, 1, 0, 8'h3C);
        chk("wr_rd_empty_cnt", 32'(wcount), 32'd1);
        step(0, 0, 0, 0, 1, 8'h00);
        chk("udf_clr", 32'(underflow), 32'd0);
        step(0, 0, 0, 1, 0, 8'h00);
        chk("read_3c", 32'(rdata), 32'h3C);

        // Flush after 5 writes with winc held, sticky flag preserved.
        step(0, 0, 0, 1, 0, 8'h00);
        for (int i = 0; i < 5; i++)
            step(0, 0, 1, 0, 0, 8'(8'h50 + i));
        step(0, 1, 1, 0, 0, 8'h77);
        chk("flush_cnt", 32'(wcount),    32'd0);
        chk("flush_udf", 32'(underflow), 32'd1);

        // Reset dominates flush/winc/err_clr with 8 entries stored.
        for (int i = 0; i < 8; i++)
            step(0, 0, 1, 0, 0, 8'(8'h90 + i));
        step(0, 0, 0, 1, 0, 8'h00);
        step(1, 1, 1, 0, 1, 8'hFF);
        chk("rst2_rempty", 32'(rempty), 32'd1);
        chk("rst2_rdata",  32'(rdata),  32'd0);

        // Random traffic in phases biased toward filling and draining.
        for (int ph = 0; ph < 6; ph++) begin
            int wp;
            wp = (ph % 2 == 0) ? 75 : 25;
            for (int i = 0; i < 80; i++) begin
                logic r, f, w, rd, ec;
                r  = ($urandom_range(0, 199) == 0);
                f  = ($urandom_range(0, 59) == 0);
                w  = ($urandom_range(0, 99) < wp);
                rd = ($urandom_range(0, 99) < (100 - wp));
                ec = ($urandom_range(0, 19) == 0);
                step(r, f, w, rd, ec, 8'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data width in bits.
REQ-002 SHALL have parameter ASIZE, default 4, address width; DEPTH = 2**ASIZE entries.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, count at or above which walmost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 2, count at or below which ralmost_empty asserts.
REQ-005 SHALL have port wclk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port wrst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port flush  input  1  synchronous clear of contents.
REQ-008 SHALL have port winc  input  1  write request.
REQ-009 SHALL have port wdata  input  DSIZE  write data.
REQ-010 SHALL have port rinc  input  1  read request.
REQ-011 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-012 SHALL have port rdata  output  DSIZE  registered read data.
REQ-013 SHALL have port wfull, walmost_full, rempty, ralmost_empty  output  1 each  status flags.
REQ-014 SHALL have port wcount  output  ASIZE+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have port overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL keep wptr and rptr of ASIZE+1 bits; low ASIZE bits address storage, MSB is wrap bit; both wrap naturally modulo 2**(ASIZE+1).
REQ-017 SHALL accept a write at an edge iff winc && (!wfull || rinc) && !flush: store wdata at wptr, wptr+1.
REQ-018 SHALL accept a read at an edge iff rinc && !rempty && !flush: rdata <= mem[rptr], rptr+1; rdata valid the cycle after the accepting edge (latency 1), held otherwise.
REQ-019 SHALL derive flags combinationally from registered pointers: rempty = (wptr==rptr); wfull = (low bits equal, MSB differ); wcount = wptr-rptr.
REQ-020 SHALL assert walmost_full iff wcount >= AF_LEVEL and ralmost_empty iff wcount <= AE_LEVEL.
REQ-021 SHALL, when full with winc && rinc, accept both; wcount stays DEPTH, wfull stays 1.
REQ-022 SHALL, when empty with winc && rinc, accept write only; read rejected, underflow set, rdata unchanged.
REQ-023 SHALL set overflow at any edge with winc && wfull && !rinc && !flush; write dropped, contents unchanged.
REQ-024 SHALL set underflow at any edge with rinc && rempty && !flush.
REQ-025 SHALL hold overflow/underflow until err_clr or wrst; an error event coincident with err_clr leaves flag set.
REQ-026 SHALL, on flush, set wptr=rptr=0 at that edge, ignore winc/rinc in that cycle, keep rdata and sticky flags.

Reset
REQ-027 SHALL, on wrst at a rising edge, set wptr=0, rptr=0, rdata=0, overflow=0, underflow=0; wrst overrides flush, winc, rinc, err_clr.
REQ-028 SHALL present after reset: rempty=1, ralmost_empty=1, wfull=0, walmost_full=0, wcount=0.
REQ-029 SHALL not require storage array reset; reads only return written entries.

Structure
REQ-030 SHALL place DSIZE/ASIZE defaults and a fifo_status_t struct (wfull, walmost_full, rempty, ralmost_empty, overflow, underflow) in shared package fifo_pkg.
REQ-031 SHALL instantiate one sub-module fifo_mem: DEPTH x DSIZE, one synchronous write port, one registered read port.
REQ-032 SHALL flag AF_LEVEL > DEPTH or AE_LEVEL >= DEPTH as an elaboration error.

Verification (DSIZE=8, ASIZE=4, AF_LEVEL=14, AE_LEVEL=2)
REQ-033 SHALL cover: wrst for 2 cycles -> rempty=1, wcount=0, wfull=0, rdata=0x00, overflow=underflow=0.
REQ-034 SHALL cover: 16 writes 0x00..0x0F -> walmost_full rises after 14th, wfull after 16th; 17th write -> overflow=1, wcount=16; 16 reads return 0x00..0x0F in order, 1-cycle latency.
REQ-035 SHALL cover: full FIFO, winc && rinc with 0xA5 for 20 cycles -> wcount stays 16, no overflow, data order preserved across pointer wrap.
REQ-036 SHALL cover: empty FIFO, rinc alone -> underflow=1, rdata held; then winc && rinc with 0x3C -> wcount=1; err_clr -> underflow=0.
REQ-037 SHALL cover: 5 writes then flush with winc=1 -> wcount=0, rempty=1, write dropped, sticky flags unchanged.
REQ-038 SHALL cover: wrst asserted with flush, winc, err_clr and 8 entries stored -> all counters and flags at reset values next cycle.
